// File: rtl/ll_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ll_fifo_pkg
// Description : Shared widths, output-stage state encoding and width helpers
//               for the linked-list FIFO arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ll_fifo_pkg;

  // Output stage: IDLE presents nothing, HOLD presents a registered word
  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_HOLD = 1'b1;

  // Buffer index width; occupancy counters use one more bit to reach DEPTH
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // FIFO selector width, never narrower than one bit
  function automatic int sel_width(input int num_fifos);
    return (num_fifos > 1) ? $clog2(num_fifos) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ll_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ll_rr_arbiter
// Description : Round-robin arbiter. Grants the first requesting index at or
//               after ptr (wrapping); returns one-hot grant and its index.
// Revision    : 1.0 - initial release
// ============================================================================
module ll_rr_arbiter #(
  parameter int N         = 1,
  parameter int SEL_WIDTH = 1
) (
  input  logic [N-1:0]         req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 any
);

  int w_cand;

  // Scan from ptr upward and take the first requester found
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = (int'(ptr) + k) % N;
      if (!any && req[w_cand]) begin
        any           = 1'b1;
        grant[w_cand] = 1'b1;
        idx           = SEL_WIDTH'(w_cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ll_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ll_fifo_arbiter
// Description : Push/pop arbiter in front of a shared-buffer linked-list
//               FIFO. Round-robin push grants with per-FIFO quota, round-robin
//               drain into a one-word registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module ll_fifo_arbiter
  import ll_fifo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int NUM_FIFOS = 1,
  parameter int QUOTA     = DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_FIFOS-1:0]             in_valid,
  input  logic [NUM_FIFOS*WIDTH-1:0]       in_data,
  output logic [NUM_FIFOS-1:0]             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [sel_width(NUM_FIFOS)-1:0]  out_sel,
  output logic                             ll_push,
  output logic                             ll_pop,
  output logic [sel_width(NUM_FIFOS)-1:0]  ll_push_sel,
  output logic [sel_width(NUM_FIFOS)-1:0]  ll_pop_sel,
  output logic [WIDTH-1:0]                 ll_data_in,
  input  logic                             ll_full,
  input  logic [NUM_FIFOS-1:0]             ll_empty,
  input  logic [WIDTH-1:0]                 ll_data_out
);

  localparam int PTR_WIDTH = ptr_width(DEPTH);
  localparam int SEL_WIDTH = sel_width(NUM_FIFOS);
  localparam int OCC_W     = PTR_WIDTH + 1;

  logic [OCC_W-1:0]     r_occ [NUM_FIFOS];
  logic [SEL_WIDTH-1:0] r_push_ptr;
  logic [SEL_WIDTH-1:0] r_pop_ptr;
  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [WIDTH-1:0]     r_out_data;
  logic [SEL_WIDTH-1:0] r_out_sel;

  logic [NUM_FIFOS-1:0] w_push_req;
  logic [NUM_FIFOS-1:0] w_push_grant;
  logic [SEL_WIDTH-1:0] w_push_idx;
  logic                 w_push_any;
  logic [NUM_FIFOS-1:0] w_pop_req;
  logic [NUM_FIFOS-1:0] w_pop_grant;
  logic [SEL_WIDTH-1:0] w_pop_idx;
  logic                 w_pop_any;
  logic                 w_pop_allowed;

  // Push eligibility: valid, under quota, buffer not full this cycle
  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_req
    assign w_push_req[i] = in_valid[i] & (r_occ[i] < OCC_W'(QUOTA)) & ~ll_full & ~rst;
  end

  // Output register can take a word when empty or when it is being drained
  assign w_pop_allowed = (r_state == c_IDLE) | out_ready;
  assign w_pop_req     = ~ll_empty & {NUM_FIFOS{w_pop_allowed & ~rst}};

  ll_rr_arbiter #(.N(NUM_FIFOS), .SEL_WIDTH(SEL_WIDTH)) u_push_arb (
    .req   (w_push_req),
    .ptr   (r_push_ptr),
    .grant (w_push_grant),
    .idx   (w_push_idx),
    .any   (w_push_any)
  );

  ll_rr_arbiter #(.N(NUM_FIFOS), .SEL_WIDTH(SEL_WIDTH)) u_pop_arb (
    .req   (w_pop_req),
    .ptr   (r_pop_ptr),
    .grant (w_pop_grant),
    .idx   (w_pop_idx),
    .any   (w_pop_any)
  );

  assign in_ready    = w_push_grant;
  assign ll_push     = w_push_any;
  assign ll_push_sel = w_push_idx;
  assign ll_data_in  = in_data[int'(w_push_idx)*WIDTH +: WIDTH];
  assign ll_pop      = w_pop_any;
  assign ll_pop_sel  = w_pop_idx;

  // Round-robin pointers move just past the index that won
  always_ff @(posedge clk) begin
    if (rst) begin
      r_push_ptr <= '0;
      r_pop_ptr  <= '0;
    end else begin
      if (w_push_any)
        r_push_ptr <= SEL_WIDTH'((int'(w_push_idx) + 1) % NUM_FIFOS);
      if (w_pop_any)
        r_pop_ptr  <= SEL_WIDTH'((int'(w_pop_idx) + 1) % NUM_FIFOS);
    end
  end

  // Per-FIFO occupancy; a same-cycle push and pop cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FIFOS; i++) r_occ[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FIFOS; i++)
        r_occ[i] <= r_occ[i] + OCC_W'(w_push_grant[i]) - OCC_W'(w_pop_grant[i]);
    end
  end

  // Output FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Output FSM next state: a pop always lands in HOLD
  always_comb begin
    w_state_nxt = r_state;
    if (w_pop_any)
      w_state_nxt = c_HOLD;
    else if ((r_state == c_HOLD) && out_ready)
      w_state_nxt = c_IDLE;
  end

  // Output FSM outputs
  always_comb begin
    out_valid = (r_state == c_HOLD);
    out_data  = r_out_data;
    out_sel   = r_out_sel;
  end

  // Capture the popped head word; held otherwise so it stays stable in HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_sel  <= '0;
    end else if (w_pop_any) begin
      r_out_data <= ll_data_out;
      r_out_sel  <= w_pop_idx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ll_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ll_fifo_arbiter
// Description : Self-checking bench. Behavioural shared-buffer FIFO on the
//               ll_* side, per-FIFO scoreboard of accepted words compared at
//               the output handshake, plus directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ll_fifo_arbiter;

  localparam int WIDTH = 4, DEPTH = 4, NUM_FIFOS = 2, QUOTA = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       in_valid;
  logic [7:0]       in_data;
  logic [1:0]       in_ready;
  logic             out_valid, out_ready;
  logic [3:0]       out_data;
  logic [0:0]       out_sel;
  logic             ll_push, ll_pop;
  logic [0:0]       ll_push_sel, ll_pop_sel;
  logic [3:0]       ll_data_in;
  logic             ll_full  = 1'b0;
  logic [1:0]       ll_empty = 2'b11;
  logic [3:0]       ll_data_out;
  logic [3:0]       h0 = '0, h1 = '0;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, pop_cnt = 0, same_seen = 0;
  logic [3:0] m0[$], m1[$];          // contents of the external FIFO model
  logic [3:0] sb0[$], sb1[$];        // words accepted at the input, per FIFO
  int         gnt_log[$];
  logic [3:0] obs_data[$];
  int         obs_sel[$], obs_cyc[$];

  always #5 clk = ~clk;

  ll_fifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NUM_FIFOS), .QUOTA(QUOTA)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .ll_push(ll_push), .ll_pop(ll_pop), .ll_push_sel(ll_push_sel), .ll_pop_sel(ll_pop_sel),
    .ll_data_in(ll_data_in), .ll_full(ll_full), .ll_empty(ll_empty), .ll_data_out(ll_data_out)
  );

  assign ll_data_out = ll_pop_sel[0] ? h1 : h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // External FIFO model, protocol checks and scoreboard
  always @(posedge clk) begin
    logic [3:0] exp_w;
    cyc <= cyc + 1;
    if (rst) begin
      check("rst_push", {31'd0, ll_push}, 0);
      check("rst_pop", {31'd0, ll_pop}, 0);
      check("rst_ready", {30'd0, in_ready}, 0);
      m0.delete(); m1.delete(); sb0.delete(); sb1.delete();
    end else begin
      if (in_valid[0] && in_ready[0]) sb0.push_back(in_data[3:0]);
      if (in_valid[1] && in_ready[1]) sb1.push_back(in_data[7:4]);
      if (out_valid && out_ready) begin
        if ((out_sel[0] ? sb1.size() : sb0.size()) == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_w = out_sel[0] ? sb1.pop_front() : sb0.pop_front();
          check("out_data", {28'd0, out_data}, {28'd0, exp_w});
        end
        obs_data.push_back(out_data);
        obs_sel.push_back(int'(out_sel));
        obs_cyc.push_back(cyc);
      end
      if (ll_pop) begin
        check("pop_empty", {31'd0, ll_empty[ll_pop_sel]}, 0);
        pop_cnt <= pop_cnt + 1;
        if (ll_push && ll_push_sel == 1'b0 && ll_pop_sel == 1'b0) same_seen <= 1;
        if (ll_pop_sel[0]) begin if (m1.size() > 0) void'(m1.pop_front()); end
        else               begin if (m0.size() > 0) void'(m0.pop_front()); end
      end
      if (ll_push) begin
        check("push_full", {31'd0, ll_full}, 0);
        gnt_log.push_back(int'(ll_push_sel));
        if (ll_push_sel[0]) m1.push_back(ll_data_in);
        else                m0.push_back(ll_data_in);
      end
    end
    ll_full  <= (m0.size() + m1.size()) >= DEPTH;
    ll_empty <= {m1.size() == 0, m0.size() == 0};
    h0       <= (m0.size() > 0) ? m0[0] : 4'h0;
    h1       <= (m1.size() > 0) ? m1[0] : 4'h0;
  end

  // Push one word into FIFO1 and let it be popped into the output register
  // while out_ready is low, so the output stage sits in HOLD afterwards
  task automatic preload(input logic [3:0] d);
    in_valid = 2'b10; in_data = {d, 4'h0};
    @(negedge clk);
    in_valid = 2'b00;
    @(negedge clk);
    check("preload_hold", {31'd0, out_valid}, 1);
  endtask

  // Drain everything; bounded wait
  task automatic drain();
    int k;
    in_valid = 2'b00; out_ready = 1'b1;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sb0.size() == 0 && sb1.size() == 0 && !out_valid && m0.size() == 0 && m1.size() == 0) break;
    end
    check("drain_done", (k < 30) ? 1 : 0, 1);
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int g0, p0, o0;
    rst = 1'b1; in_valid = 2'b11; in_data = 8'hFF; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", {28'd0, out_data}, 0);
    check("rst_out_sel", {31'd0, out_sel}, 0);
    check("rst_in_ready", {30'd0, in_ready}, 0);
    rst = 1'b0; in_valid = 2'b00;
    @(negedge clk);

    // Both requesters held valid with the output stage occupied: 0,1,0,1 then full
    preload(4'hE);
    g0 = gnt_log.size();
    in_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      in_data = {4'(8 + k), 4'(k)};
      @(negedge clk);
    end
    check("rr_grants", gnt_log.size() - g0, 4);
    for (int k = 0; k < 4; k++)
      if (g0 + k < gnt_log.size()) check($sformatf("rr_grant%0d", k), gnt_log[g0 + k], k % 2);
    check("rr_full", {31'd0, ll_full}, 1);
    #1 check("rr_no_ready", {30'd0, in_ready}, 0);
    drain();

    // Single requester stops at quota while the buffer still has room
    preload(4'hD);
    g0 = gnt_log.size();
    in_valid = 2'b01;
    for (int k = 0; k < 6; k++) begin
      in_data = {4'h0, 4'(3 + k)};
      @(negedge clk);
    end
    check("quota_grants", gnt_log.size() - g0, 3);
    check("quota_not_full", {31'd0, ll_full}, 0);
    #1 check("quota_no_ready", {31'd0, in_ready[0]}, 0);
    drain();

    // Round-robin drain order A(0), C(1), B(0), back-to-back
    preload(4'h9);
    in_valid = 2'b01; in_data = {4'h0, 4'hA}; @(negedge clk);
    in_valid = 2'b10; in_data = {4'hC, 4'h0}; @(negedge clk);
    in_valid = 2'b01; in_data = {4'h0, 4'hB}; @(negedge clk);
    in_valid = 2'b00;
    o0 = obs_data.size();
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    out_ready = 1'b0;
    check("order_count", obs_data.size() - o0, 4);
    if (obs_data.size() - o0 == 4) begin
      check("order_0_data", {28'd0, obs_data[o0]}, 32'h9);
      check("order_1_data", {28'd0, obs_data[o0 + 1]}, 32'hA);
      check("order_1_sel", obs_sel[o0 + 1], 0);
      check("order_2_data", {28'd0, obs_data[o0 + 2]}, 32'hC);
      check("order_2_sel", obs_sel[o0 + 2], 1);
      check("order_3_data", {28'd0, obs_data[o0 + 3]}, 32'hB);
      check("order_3_sel", obs_sel[o0 + 3], 0);
      check("order_spacing", obs_cyc[o0 + 3] - obs_cyc[o0 + 1], 2);
    end
    drain();

    // Back-pressure in HOLD: word stable, a single pop
    p0 = pop_cnt;
    in_valid = 2'b01; in_data = {4'h0, 4'h5}; @(negedge clk);
    in_valid = 2'b00; @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", {31'd0, out_valid}, 1);
      check("stall_data", {28'd0, out_data}, 32'h5);
      check("stall_sel", {31'd0, out_sel}, 0);
      @(negedge clk);
    end
    check("stall_pops", pop_cnt - p0, 1);
    drain();

    // Same-cycle push and pop of FIFO0 with one word stored
    o0 = obs_data.size();
    in_valid = 2'b01; in_data = {4'h0, 4'h3}; @(negedge clk);
    in_data = {4'h0, 4'h7}; @(negedge clk);
    in_valid = 2'b00;
    check("same_cycle_seen", same_seen, 1);
    check("same_occ0", {29'd0, dut.r_occ[0]}, 1);
    check("same_model_sz", m0.size(), 1);
    drain();
    check("same_order_count", obs_data.size() - o0, 2);
    if (obs_data.size() - o0 == 2) begin
      check("same_first", {28'd0, obs_data[o0]}, 32'h3);
      check("same_second", {28'd0, obs_data[o0 + 1]}, 32'h7);
    end

    // Reset while holding an output word and with a push pending
    preload(4'hC);
    in_valid = 2'b01; in_data = {4'h0, 4'h6}; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", {31'd0, out_valid}, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 2'b00;
    @(negedge clk);
    check("rst_mid_occ0", {29'd0, dut.r_occ[0]}, 0);
    check("rst_mid_occ1", {29'd0, dut.r_occ[1]}, 0);
    check("rst_mid_out_data", {28'd0, out_data}, 0);
    check("rst_mid_valid2", {31'd0, out_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
